// File: rtl/l2_busif.sv
// L2 bus-side miss/writeback queue: four entries arbitrate for 8-cycle bus frames, retry on nack,
// gather tag-matched 8-beat fills and hand whole 64B lines back to the cache (lowest filled entry first).
module l2_busif #(
    parameter logic [2:0] AGENT_ID = 3'd1,
    parameter int         NENT     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [2:0]   req_cmd,
    input  logic [25:0]  req_addr,
    input  logic [511:0] req_data,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [25:0]  resp_addr,
    output logic [511:0] resp_data,
    input  logic         bus_valid,
    input  logic         bus_nack,
    input  logic [2:0]   bus_cmd,
    input  logic [4:0]   bus_tag,
    input  logic [63:0]  bus_data,
    output logic         busif_bus_req,
    output logic [2:0]   busif_bus_cmd,
    output logic [4:0]   busif_bus_tag,
    output logic [25:0]  busif_bus_addr,
    output logic [63:0]  busif_bus_data,
    input  logic         bus_busif_grant
);
    // Bus command encoding shared with buscmd.vh
    localparam logic [2:0] CMD_FLUSH = 3'd4;
    localparam logic [2:0] CMD_FILL  = 3'd5;

    typedef enum logic [2:0] {
        ST_FREE,
        ST_PEND,
        ST_ISSUED,
        ST_WAITF,
        ST_FILLED
    } state_t;

    state_t        r_state [NENT];
    logic [2:0]    r_cmd   [NENT];
    logic [25:0]   r_addr  [NENT];
    logic [511:0]  r_data  [NENT];

    logic [2:0]    r_cyc;
    logic          r_bus_req;
    logic [1:0]    r_issue_idx;
    logic          r_own;
    logic [1:0]    r_own_idx;
    logic          r_nack;
    logic          r_fill_act;
    logic [1:0]    r_fill_idx;
    logic [2:0]    r_bus_cmd;
    logic [4:0]    r_bus_tag;
    logic [25:0]   r_bus_addr;
    logic [63:0]   r_bus_data;

    logic          w_grant;
    logic          w_free_found;
    logic [1:0]    w_free_idx;
    logic          w_resp_found;
    logic [1:0]    w_resp_idx;
    logic          w_pend_found;
    logic [1:0]    w_pend_idx;
    logic [1:0]    w_fill_slot;
    logic          w_fill_hit;
    logic          w_own_flush;
    logic [2:0]    w_beat_nxt;

    assign w_grant     = (r_cyc == 3'd7) && r_bus_req && bus_busif_grant;
    assign w_fill_slot = bus_tag[1:0];
    assign w_fill_hit  = (r_cyc == 3'd0) && bus_valid && (bus_cmd == CMD_FILL) &&
                         (bus_tag[4:2] == AGENT_ID) && (r_state[w_fill_slot] == ST_WAITF);
    assign w_own_flush = (r_cmd[r_own_idx] == CMD_FLUSH);
    assign w_beat_nxt  = r_cyc + 3'd1;

    // Lowest-index priority; the entry being granted this edge is not a candidate for the next request.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = 2'd0;
        w_resp_found = 1'b0;
        w_resp_idx   = 2'd0;
        w_pend_found = 1'b0;
        w_pend_idx   = 2'd0;
        for (int i = NENT - 1; i >= 0; i--) begin
            if (r_state[i] == ST_FREE) begin
                w_free_found = 1'b1;
                w_free_idx   = 2'(i);
            end
            if (r_state[i] == ST_FILLED) begin
                w_resp_found = 1'b1;
                w_resp_idx   = 2'(i);
            end
            if ((r_state[i] == ST_PEND) && !(w_grant && (r_issue_idx == 2'(i)))) begin
                w_pend_found = 1'b1;
                w_pend_idx   = 2'(i);
            end
        end
    end

    assign req_ready      = w_free_found;
    assign resp_valid     = w_resp_found;
    assign resp_addr      = r_addr[w_resp_idx];
    assign resp_data      = r_data[w_resp_idx];
    assign busif_bus_req  = r_bus_req;
    assign busif_bus_cmd  = r_bus_cmd;
    assign busif_bus_tag  = r_bus_tag;
    assign busif_bus_addr = r_bus_addr;
    assign busif_bus_data = r_bus_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc       <= 3'd0;
            for (int i = 0; i < NENT; i++) r_state[i] <= ST_FREE;
            r_bus_req   <= 1'b0;
            r_issue_idx <= 2'd0;
            r_own       <= 1'b0;
            r_own_idx   <= 2'd0;
            r_nack      <= 1'b0;
            r_fill_act  <= 1'b0;
            r_fill_idx  <= 2'd0;
            r_bus_cmd   <= 3'd0;
            r_bus_tag   <= 5'd0;
            r_bus_addr  <= 26'd0;
            r_bus_data  <= 64'd0;
        end else begin
            r_cyc <= r_cyc + 3'd1;
            if (req_valid && w_free_found)
                r_state[w_free_idx] <= ST_PEND;
            if (w_resp_found && resp_ready)
                r_state[w_resp_idx] <= ST_FREE;

            if (w_fill_hit) begin
                r_fill_act <= 1'b1;
                r_fill_idx <= w_fill_slot;
            end else if (r_fill_act && (r_cyc == 3'd7)) begin
                r_fill_act          <= 1'b0;
                r_state[r_fill_idx] <= ST_FILLED;
            end

            if (r_own && (r_cyc == 3'd4))
                r_nack <= bus_nack;

            if (r_cyc == 3'd7) begin
                r_bus_req   <= w_pend_found;
                r_issue_idx <= w_pend_idx;
                // A nacked entry only rejoins arbitration at the following frame boundary.
                if (r_own)
                    r_state[r_own_idx] <= r_nack ? ST_PEND :
                                          (w_own_flush ? ST_FREE : ST_WAITF);
                if (w_grant) begin
                    r_own                <= 1'b1;
                    r_own_idx            <= r_issue_idx;
                    r_nack               <= 1'b0;
                    r_state[r_issue_idx] <= ST_ISSUED;
                    r_bus_cmd            <= r_cmd[r_issue_idx];
                    r_bus_tag            <= {AGENT_ID, r_issue_idx};
                    r_bus_addr           <= r_addr[r_issue_idx];
                    r_bus_data           <= (r_cmd[r_issue_idx] == CMD_FLUSH) ?
                                            r_data[r_issue_idx][63:0] : 64'd0;
                end else begin
                    r_own      <= 1'b0;
                    r_bus_cmd  <= 3'd0;
                    r_bus_tag  <= 5'd0;
                    r_bus_addr <= 26'd0;
                    r_bus_data <= 64'd0;
                end
            end else if (r_own) begin
                r_bus_data <= w_own_flush ? r_data[r_own_idx][64*w_beat_nxt +: 64] : 64'd0;
            end
        end
    end

    // Line storage: writeback data on accept, overwritten beat by beat by the matching fill.
    always_ff @(posedge clk) begin
        if (req_valid && w_free_found) begin
            r_cmd[w_free_idx]  <= req_cmd;
            r_addr[w_free_idx] <= req_addr;
            r_data[w_free_idx] <= req_data;
        end
        if (w_fill_hit)
            r_data[w_fill_slot][63:0] <= bus_data;
        else if (r_fill_act)
            r_data[r_fill_idx][64*r_cyc +: 64] <= bus_data;
    end

endmodule

// File: tb/tb_l2_busif.sv
module tb_l2_busif;
    localparam logic [2:0] CMD_BUSRD  = 3'd1;
    localparam logic [2:0] CMD_BUSRDX = 3'd2;
    localparam logic [2:0] CMD_FLUSH  = 3'd4;
    localparam logic [2:0] CMD_FILL   = 3'd5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0, req_ready;
    logic [2:0]   req_cmd = 3'd0;
    logic [25:0]  req_addr = 26'd0;
    logic [511:0] req_data = '0;
    logic         resp_valid, resp_ready = 1'b0;
    logic [25:0]  resp_addr;
    logic [511:0] resp_data;
    logic         bus_valid = 1'b0, bus_nack = 1'b0;
    logic [2:0]   bus_cmd = 3'd0;
    logic [4:0]   bus_tag = 5'd0;
    logic [63:0]  bus_data = 64'd0;
    logic         busif_bus_req;
    logic [2:0]   busif_bus_cmd;
    logic [4:0]   busif_bus_tag;
    logic [25:0]  busif_bus_addr;
    logic [63:0]  busif_bus_data;
    logic         bus_busif_grant = 1'b0;

    l2_busif dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_addr(resp_addr), .resp_data(resp_data),
        .bus_valid(bus_valid), .bus_nack(bus_nack), .bus_cmd(bus_cmd),
        .bus_tag(bus_tag), .bus_data(bus_data),
        .busif_bus_req(busif_bus_req), .busif_bus_cmd(busif_bus_cmd),
        .busif_bus_tag(busif_bus_tag), .busif_bus_addr(busif_bus_addr),
        .busif_bus_data(busif_bus_data), .bus_busif_grant(bus_busif_grant)
    );

    always #5 clk = ~clk;

    // Bus frame position as seen by every agent, plus absolute cycle time.
    logic [2:0] tb_cyc = 3'd0;
    longint     tb_t = 0;
    always @(posedge clk) begin
        tb_t   <= tb_t + 1;
        tb_cyc <= rst ? 3'd0 : tb_cyc + 3'd1;
    end

    // Reference model: one record per queue slot, allocated lowest-free-first.
    bit           m_used   [4];
    bit           m_issued [4];
    logic [2:0]   m_cmd    [4];
    logic [25:0]  m_addr   [4];
    logic [511:0] m_data   [4];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [2:0] rand_cmd();
        case ($urandom_range(0, 2))
            0:       return CMD_BUSRD;
            1:       return CMD_BUSRDX;
            default: return CMD_FLUSH;
        endcase
    endfunction

    task automatic enq(input logic [2:0] c, input logic [25:0] a, input logic [511:0] d, output int slot);
        slot = -1;
        for (int i = 3; i >= 0; i--) if (!m_used[i]) slot = i;
        chk("enq_ready", 512'(req_ready), 512'(1));
        req_valid = 1'b1; req_cmd = c; req_addr = a; req_data = d;
        step();
        req_valid = 1'b0;
        if (slot >= 0) begin
            m_used[slot] = 1'b1; m_issued[slot] = 1'b0;
            m_cmd[slot] = c; m_addr[slot] = a; m_data[slot] = d;
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (!(tb_cyc == 3'd7 && busif_bus_req === 1'b1) && n < 200) begin
            step();
            n++;
        end
        chk("req_timeout", 512'(n < 200), 512'(1));
    endtask

    // Grant one frame, capture what the DUT drives, and score it against the model.
    task automatic issue_check(input bit nack, output int slot, output longint t0);
        logic [2:0]   c;
        logic [4:0]   tg;
        logic [25:0]  a;
        logic [511:0] d;
        wait_req();
        bus_busif_grant = 1'b1;
        step();
        bus_busif_grant = 1'b0;
        t0 = tb_t;
        c = busif_bus_cmd; tg = busif_bus_tag; a = busif_bus_addr;
        for (int k = 0; k < 8; k++) begin
            d[64*k +: 64] = busif_bus_data;
            bus_nack = (k == 4) ? nack : 1'b0;
            step();
        end
        bus_nack = 1'b0;
        chk("frame_end_cmd", 512'(busif_bus_cmd), 512'(0));
        chk("frame_end_tag", 512'(busif_bus_tag), 512'(0));
        chk("frame_end_data", 512'(busif_bus_data), 512'(0));
        slot = int'(tg[1:0]);
        chk("tag_agent", 512'(tg[4:2]), 512'(3'd1));
        chk("issue_live", 512'(m_used[slot]), 512'(1));
        chk("issue_dup", 512'(m_issued[slot]), 512'(0));
        chk("issue_cmd", 512'(c), 512'(m_cmd[slot]));
        chk("issue_addr", 512'(a), 512'(m_addr[slot]));
        chk("issue_data", d, (m_cmd[slot] == CMD_FLUSH) ? m_data[slot] : '0);
        if (!nack) begin
            if (m_cmd[slot] == CMD_FLUSH) m_used[slot] = 1'b0;
            else                          m_issued[slot] = 1'b1;
        end
    endtask

    task automatic send_fill(input logic [4:0] tag, input logic [511:0] d);
        int n = 0;
        while (tb_cyc != 3'd0 && n < 16) begin
            step();
            n++;
        end
        bus_valid = 1'b1; bus_cmd = CMD_FILL; bus_tag = tag;
        for (int k = 0; k < 8; k++) begin
            bus_data = d[64*k +: 64];
            step();
        end
        bus_valid = 1'b0; bus_cmd = 3'd0; bus_tag = 5'd0; bus_data = 64'd0;
    endtask

    task automatic fill(input int slot, input logic [511:0] d);
        m_data[slot] = d;
        send_fill({3'd1, 2'(slot)}, d);
    endtask

    task automatic take_resp(input int slot);
        int n = 0;
        while (resp_valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("resp_timeout", 512'(n < 50), 512'(1));
        chk("resp_addr", 512'(resp_addr), 512'(m_addr[slot]));
        chk("resp_data", resp_data, m_data[slot]);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        m_used[slot] = 1'b0;
        m_issued[slot] = 1'b0;
    endtask

    // Completes exactly one entry's non-nacked frame (optionally after one nacked frame).
    task automatic serve_one(input bit nack_first);
        int     s;
        longint t;
        if (nack_first) issue_check(1'b1, s, t);
        issue_check(1'b0, s, t);
        if (m_cmd[s] != CMD_FLUSH) begin
            fill(s, rand512());
            take_resp(s);
        end else begin
            chk("flush_no_resp", 512'(resp_valid), 512'(0));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int           s;
        int           nq;
        longint       ta, tb2, tc;
        logic [511:0] v;

        repeat (3) step();
        rst = 1'b0;
        chk("rst_req_ready", 512'(req_ready), 512'(1));
        chk("rst_resp_valid", 512'(resp_valid), 512'(0));
        chk("rst_bus_req", 512'(busif_bus_req), 512'(0));
        chk("rst_bus_cmd", 512'(busif_bus_cmd), 512'(0));
        chk("rst_bus_tag", 512'(busif_bus_tag), 512'(0));
        chk("rst_bus_addr", 512'(busif_bus_addr), 512'(0));
        chk("rst_bus_data", 512'(busif_bus_data), 512'(0));

        // 1: single BUSRD, fill beat k = k
        enq(CMD_BUSRD, 26'h0800001, rand512(), s);
        issue_check(1'b0, s, ta);
        chk("t1_slot", 512'(s), 512'(0));
        for (int k = 0; k < 8; k++) v[64*k +: 64] = 64'(k);
        fill(0, v);
        chk("t1_resp_valid", 512'(resp_valid), 512'(1));
        take_resp(0);
        chk("t1_resp_clear", 512'(resp_valid), 512'(0));
        chk("t1_ready", 512'(req_ready), 512'(1));

        // 2: FLUSH drives beats 0xA0+k, no response
        for (int k = 0; k < 8; k++) v[64*k +: 64] = 64'(8'hA0 + k);
        enq(CMD_FLUSH, 26'h0123456, v, s);
        issue_check(1'b0, s, ta);
        chk("t2_no_resp", 512'(resp_valid), 512'(0));
        chk("t2_ready", 512'(req_ready), 512'(1));

        // 3: BUSRDX nacked twice, idle frame between retries
        enq(CMD_BUSRDX, 26'h2ABCDEF, rand512(), s);
        issue_check(1'b1, s, ta);
        chk("t3_slot_a", 512'(s), 512'(0));
        issue_check(1'b1, s, tb2);
        chk("t3_slot_b", 512'(s), 512'(0));
        chk("t3_gap_ab", 512'((tb2 - ta) >= 16), 512'(1));
        issue_check(1'b0, s, tc);
        chk("t3_slot_c", 512'(s), 512'(0));
        chk("t3_gap_bc", 512'((tc - tb2) >= 16), 512'(1));
        fill(0, rand512());
        take_resp(0);
        chk("t3_single", 512'(resp_valid), 512'(0));

        // 4: fifth request waits for a freed entry
        for (int i = 0; i < 4; i++) enq(CMD_BUSRD, 26'h100 + 26'(i), rand512(), s);
        chk("t4_full", 512'(req_ready), 512'(0));
        v = rand512();
        req_valid = 1'b1; req_cmd = CMD_BUSRD; req_addr = 26'h1FF; req_data = v;
        step();
        chk("t4_held", 512'(req_ready), 512'(0));
        serve_one(1'b0);
        chk("t4_ready_next", 512'(req_ready), 512'(1));
        s = -1;
        for (int i = 3; i >= 0; i--) if (!m_used[i]) s = i;
        step();
        req_valid = 1'b0;
        if (s >= 0) begin
            m_used[s] = 1'b1; m_issued[s] = 1'b0;
            m_cmd[s] = CMD_BUSRD; m_addr[s] = 26'h1FF; m_data[s] = v;
        end
        chk("t4_full_again", 512'(req_ready), 512'(0));
        repeat (4) serve_one(1'b0);

        // 5: out-of-order fills, lowest filled entry presented; foreign/stale tags ignored
        for (int i = 0; i < 3; i++) enq(CMD_BUSRD, 26'h2A0 + 26'(i), rand512(), s);
        repeat (3) issue_check(1'b0, s, ta);
        fill(2, rand512());
        chk("t5_first_valid", 512'(resp_valid), 512'(1));
        chk("t5_first_addr", 512'(resp_addr), 512'(m_addr[2]));
        fill(0, rand512());
        chk("t5_lowest_addr", 512'(resp_addr), 512'(m_addr[0]));
        send_fill(5'h08, rand512());
        send_fill(5'h04, rand512());
        chk("t5_ignored_addr", 512'(resp_addr), 512'(m_addr[0]));
        chk("t5_ignored_data", resp_data, m_data[0]);
        take_resp(0);
        chk("t5_next_addr", 512'(resp_addr), 512'(m_addr[2]));
        take_resp(2);
        fill(1, rand512());
        take_resp(1);

        // Randomized traffic against the model
        for (int it = 0; it < 6; it++) begin
            nq = $urandom_range(1, 3);
            for (int j = 0; j < nq; j++) enq(rand_cmd(), 26'($urandom), rand512(), s);
            for (int j = 0; j < nq; j++) serve_one(1'($urandom_range(0, 1)));
        end
        chk("rand_idle_valid", 512'(resp_valid), 512'(0));
        chk("rand_idle_ready", 512'(req_ready), 512'(1));

        // 6: reset during own frame at cyc 3
        enq(CMD_BUSRD, 26'h3F00AB, rand512(), s);
        wait_req();
        bus_busif_grant = 1'b1;
        step();
        bus_busif_grant = 1'b0;
        chk("t6_own_cmd", 512'(busif_bus_cmd), 512'(CMD_BUSRD));
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_used[i] = 1'b0;
            m_issued[i] = 1'b0;
        end
        chk("t6_bus_req", 512'(busif_bus_req), 512'(0));
        chk("t6_bus_cmd", 512'(busif_bus_cmd), 512'(0));
        chk("t6_bus_tag", 512'(busif_bus_tag), 512'(0));
        chk("t6_bus_addr", 512'(busif_bus_addr), 512'(0));
        chk("t6_bus_data", 512'(busif_bus_data), 512'(0));
        chk("t6_req_ready", 512'(req_ready), 512'(1));
        chk("t6_resp_valid", 512'(resp_valid), 512'(0));
        send_fill(5'h04, rand512());
        repeat (2) step();
        chk("t6_stale_fill", 512'(resp_valid), 512'(0));
        chk("t6_no_req", 512'(busif_bus_req), 512'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
